// File: rtl/wb_dbus_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter for the SoC data bus.
// Round-robin grant, one transfer per grant, watchdog answers a silent slave with err.
module wb_dbus_arbiter2 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  owner_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic        req0, req1;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic        own_we, own_cyc, own_stb;
  logic        timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Owner's bus; all zeros while idle.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (state_q)
      StOwn0: begin
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        own_sel = m0_sel_i;
        own_we  = m0_we_i;
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      StOwn1: begin
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
        own_sel = m1_sel_i;
        own_we  = m1_we_i;
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  // Ack beats timeout, and an owner that already dropped cyc gets no err.
  assign timeout = own_cyc & ~s_ack_i & (cnt_q == CntLast);

  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we;
  assign s_cyc_o = own_cyc & ~timeout;
  assign s_stb_o = own_stb & ~timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state_q == StOwn0) & s_ack_i;
  assign m1_ack_o = (state_q == StOwn1) & s_ack_i;
  assign m0_err_o = (state_q == StOwn0) & timeout;
  assign m1_err_o = (state_q == StOwn1) & timeout;

  assign owner_o = {state_q == StOwn1, state_q == StOwn0};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // On a tie, last_q set means m1 was served last, so m0 goes next.
        if (req0 && (!req1 || last_q)) begin
          state_d = StOwn0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (req1) begin
          state_d = StOwn1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StOwn0, StOwn1: begin
        if (s_ack_i || !own_cyc || timeout) begin
          state_d = StIdle;
        end else if (own_stb && (cnt_q != 8'hff)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
